// File: rtl/osc_voice_mixer.sv
// -----------------------------------------------------------------------------
// osc_voice_mixer
//
// Purpose:
//   Takes the time-multiplexed sine samples of every (voice, osc) slot, scales
//   each one by its envelope level, zeroes slots of free voices, and adds all
//   slots of a frame into one mixed sample. It also checks that the slots
//   arrive in order.
//
//   Slot order: ox counts fastest, (0,0) .. (VOICES-1, V_OSC-1).
//   Cycles with slot_valid=0 are gaps. State holds during a gap.
//
//   Latency: the last slot sampled at edge N updates mix_out, voice_active_cnt
//   and mix_valid at edge N+2.
//
// Handshake:
//   slot_valid is a qualifier with no back-pressure. A slot counts only in a
//   cycle where slot_valid=1. mix_valid is a one-cycle pulse, and mix_out and
//   voice_active_cnt hold their values between pulses.
//
// Optional feature:
//   OSC_VOICE_MIXER_SAT_EN - when defined, the frame sum saturates to
//   OUT_WIDTH. When undefined, it wraps in two's complement.
//
// Ports:
//   sCLK_XVXENVS      clock
//   reset_reg         asynchronous active-high reset
//   slot_valid        slot qualifier for vx/ox/sine_in/env_level
//   vx, ox            voice / osc index of the current slot
//   sine_in           17-bit signed sine sample
//   env_level         8-bit unsigned envelope level
//   voice_free        1 = voice idle, so its slots add 0
//   seq_err_clr       clears the sticky seq_err flag (a set in the same cycle wins)
//   mix_out           signed mixed frame sample
//   mix_valid         one-cycle pulse when mix_out updates
//   voice_active_cnt  number of non-free voices in the last frame
//   seq_err           sticky slot-sequence error
// -----------------------------------------------------------------------------
module osc_voice_mixer #(
    parameter int VOICES    = 8,
    parameter int V_OSC     = 4,
    parameter int V_WIDTH   = 3,
    parameter int O_WIDTH   = 2,
    parameter int OUT_WIDTH = 20,
    parameter int ACC_WIDTH = 18 + V_WIDTH + O_WIDTH
) (
    input  logic                 sCLK_XVXENVS,
    input  logic                 reset_reg,
    input  logic                 slot_valid,
    input  logic [V_WIDTH-1:0]   vx,
    input  logic [O_WIDTH-1:0]   ox,
    input  logic [16:0]          sine_in,
    input  logic [7:0]           env_level,
    input  logic [VOICES-1:0]    voice_free,
    input  logic                 seq_err_clr,
    output logic [OUT_WIDTH-1:0] mix_out,
    output logic                 mix_valid,
    output logic [V_WIDTH:0]     voice_active_cnt,
    output logic                 seq_err
);

    localparam int SLOT_W = V_WIDTH + O_WIDTH;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(VOICES * V_OSC - 1);

    typedef enum logic {ST_SYNC, ST_RUN} state_t;

    state_t                        state_q, state_d;
    logic [SLOT_W-1:0]             exp_slot_q, exp_slot_d;
    logic                          seq_err_q, seq_err_d;

    logic                          s1_valid_q, s1_valid_d;
    logic                          s1_first_q, s1_first_d;
    logic                          s1_last_q, s1_last_d;
    logic                          s1_active_q, s1_active_d;
    logic signed [17:0]            s1_scaled_q, s1_scaled_d;

    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [V_WIDTH:0]              cnt_q, cnt_d;
    logic                          s2_done_q, s2_done_d;

    logic [OUT_WIDTH-1:0]          mix_out_q, mix_out_d;
    logic                          mix_valid_q, mix_valid_d;
    logic [V_WIDTH:0]              cnt_out_q, cnt_out_d;

    logic [SLOT_W-1:0]             slot_idx;
    logic                          accept, first, last, seq_err_set;
    logic signed [25:0]            prod;

    assign slot_idx = {vx, ox};

    // Tracks the expected slot, decides whether to accept the slot, and marks frame boundaries.
    always_comb begin
        state_d     = state_q;
        exp_slot_d  = exp_slot_q;
        accept      = 1'b0;
        first       = 1'b0;
        last        = 1'b0;
        seq_err_set = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (slot_valid && slot_idx == '0) begin
                    accept     = 1'b1;
                    first      = 1'b1;
                    exp_slot_d = SLOT_W'(1);
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (slot_valid) begin
                    if (slot_idx == exp_slot_q) begin
                        accept     = 1'b1;
                        first      = (exp_slot_q == '0);
                        last       = (exp_slot_q == LAST_SLOT);
                        // The slot count is a power of two, so this wraps to (0,0) after the last slot.
                        exp_slot_d = exp_slot_q + SLOT_W'(1);
                    end else begin
                        seq_err_set = 1'b1;
                        if (slot_idx == '0) begin
                            // An out-of-order (0,0) starts a new frame immediately.
                            accept     = 1'b1;
                            first      = 1'b1;
                            exp_slot_d = SLOT_W'(1);
                        end else begin
                            state_d    = ST_SYNC;
                            exp_slot_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d    = ST_SYNC;
                exp_slot_d = '0;
            end
        endcase
    end

    // Stage 1: scale by envelope. A signed 17x9 product shifted right by 8
    // always fits in 18 bits, so a slice of the product is enough.
    assign prod = $signed(sine_in) * $signed({1'b0, env_level});

    always_comb begin
        s1_valid_d  = accept;
        s1_first_d  = first;
        s1_last_d   = last;
        s1_scaled_d = voice_free[vx] ? 18'sd0 : prod[25:8];
        s1_active_d = (ox == '0) && !voice_free[vx];
    end

    // Stage 2: accumulate. A partial frame left by a sequence error is dropped
    // because the next frame's first slot reloads the accumulator.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        s2_done_d = s1_valid_q && s1_last_q;
        if (s1_valid_q) begin
            if (s1_first_q) begin
                acc_d = {{(ACC_WIDTH-18){s1_scaled_q[17]}}, s1_scaled_q};
                cnt_d = {{V_WIDTH{1'b0}}, s1_active_q};
            end else begin
                acc_d = acc_q + {{(ACC_WIDTH-18){s1_scaled_q[17]}}, s1_scaled_q};
                cnt_d = cnt_q + {{V_WIDTH{1'b0}}, s1_active_q};
            end
        end
    end

`ifdef OSC_VOICE_MIXER_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        ACC_WIDTH'(-(64'sd1 <<< (OUT_WIDTH-1)));
    logic unused_bits;
    assign unused_bits = ^prod[7:0];
`else
    logic unused_bits;
    assign unused_bits = ^{prod[7:0], acc_q[ACC_WIDTH-1:OUT_WIDTH]};
`endif

    // Output stage: register the completed frame one edge after its last add.
    always_comb begin
        mix_out_d   = mix_out_q;
        cnt_out_d   = cnt_out_q;
        mix_valid_d = s2_done_q;
        if (s2_done_q) begin
            cnt_out_d = cnt_q;
`ifdef OSC_VOICE_MIXER_SAT_EN
            if (acc_q > SAT_MAX) begin
                mix_out_d = SAT_MAX[OUT_WIDTH-1:0];
            end else if (acc_q < SAT_MIN) begin
                mix_out_d = SAT_MIN[OUT_WIDTH-1:0];
            end else begin
                mix_out_d = acc_q[OUT_WIDTH-1:0];
            end
`else
            mix_out_d = acc_q[OUT_WIDTH-1:0];
`endif
        end
    end

    // If a set and a clear arrive in the same cycle, the set wins.
    always_comb begin
        seq_err_d = seq_err_q;
        if (seq_err_set) begin
            seq_err_d = 1'b1;
        end else if (seq_err_clr) begin
            seq_err_d = 1'b0;
        end
    end

    always_ff @(posedge sCLK_XVXENVS or posedge reset_reg) begin
        if (reset_reg) begin
            state_q     <= ST_SYNC;
            exp_slot_q  <= '0;
            seq_err_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_active_q <= 1'b0;
            s1_scaled_q <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            s2_done_q   <= 1'b0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            cnt_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            exp_slot_q  <= exp_slot_d;
            seq_err_q   <= seq_err_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_active_q <= s1_active_d;
            s1_scaled_q <= s1_scaled_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            s2_done_q   <= s2_done_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            cnt_out_q   <= cnt_out_d;
        end
    end

    assign mix_out          = mix_out_q;
    assign mix_valid        = mix_valid_q;
    assign voice_active_cnt = cnt_out_q;
    assign seq_err          = seq_err_q;

endmodule

// File: tb/tb_osc_voice_mixer.sv
// -----------------------------------------------------------------------------
// tb_osc_voice_mixer
//
// Drives frames of slots, which may be constant or random, with or without
// gaps. A reference model computes each frame's mix from plain arithmetic
// over the slot values. The expected result and its arrival cycle are pushed
// into a queue, and a monitor pops and compares an entry on every mix_valid.
// -----------------------------------------------------------------------------
module tb_osc_voice_mixer;

  localparam int VOICES    = 8;
  localparam int V_OSC     = 4;
  localparam int V_WIDTH   = 3;
  localparam int O_WIDTH   = 2;
  localparam int OUT_WIDTH = 20;
  localparam int EW        = OUT_WIDTH + V_WIDTH + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 slot_valid;
  logic [V_WIDTH-1:0]   vx;
  logic [O_WIDTH-1:0]   ox;
  logic [16:0]          sine_in;
  logic [7:0]           env_level;
  logic [VOICES-1:0]    voice_free;
  logic                 seq_err_clr;
  logic [OUT_WIDTH-1:0] mix_out;
  logic                 mix_valid;
  logic [V_WIDTH:0]     voice_active_cnt;
  logic                 seq_err;

  osc_voice_mixer dut (
    .sCLK_XVXENVS     (clk),
    .reset_reg        (rst),
    .slot_valid       (slot_valid),
    .vx               (vx),
    .ox               (ox),
    .sine_in          (sine_in),
    .env_level        (env_level),
    .voice_free       (voice_free),
    .seq_err_clr      (seq_err_clr),
    .mix_out          (mix_out),
    .mix_valid        (mix_valid),
    .voice_active_cnt (voice_active_cnt),
    .seq_err          (seq_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            total = 0;
  int            bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reduces the frame sum to OUT_WIDTH bits, as mix_out should report it.
  function automatic int reduce(input int acc);
    int hi;
    int v;
    hi = (1 << (OUT_WIDTH - 1)) - 1;
`ifdef OSC_VOICE_MIXER_SAT_EN
    if (acc > hi) return hi;
    if (acc < -hi - 1) return -hi - 1;
    return acc;
`else
    v = acc & ((1 << OUT_WIDTH) - 1);
    if (v > hi) v = v - (1 << OUT_WIDTH);
    return v;
`endif
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int            ec;
    int            m;
    int            me;
    if (!rst && mix_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_mix_valid: got mix_out=%0d expected no pulse (cycle %0d)",
                 $signed(mix_out), cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        m  = $signed(mix_out);
        me = $signed(e[OUT_WIDTH-1:0]);
        check("mix_out", m, me);
        check("voice_active_cnt", int'(voice_active_cnt), int'(e[EW-1:OUT_WIDTH]));
        check("mix_valid_cycle", cyc, ec);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_slot(input int v, input int o, input int s, input int e);
    @(negedge clk);
    slot_valid = 1'b1;
    vx         = v[V_WIDTH-1:0];
    ox         = o[O_WIDTH-1:0];
    sine_in    = s[16:0];
    env_level  = e[7:0];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      slot_valid = 1'b0;
    end
  endtask

  // gap_mode: 0 = back-to-back, 1 = one gap before every slot, 2 = 0..2 random gaps
  task automatic send_frame(input logic [VOICES-1:0] free, input bit rnd,
                            input int cs, input int ce, input int gap_mode);
    int acc;
    int cnt;
    int s;
    int e;
    int r;
    logic [EW-1:0] ent;
    acc = 0;
    cnt = 0;
    for (int v = 0; v < VOICES; v++) if (!free[v]) cnt++;
    for (int v = 0; v < VOICES; v++) begin
      for (int o = 0; o < V_OSC; o++) begin
        if (gap_mode == 1) idle(1);
        else if (gap_mode == 2) idle(int'($urandom_range(0, 2)));
        s = rnd ? int'($urandom_range(0, 131071)) - 65536 : cs;
        e = rnd ? int'($urandom_range(0, 255)) : ce;
        drive_slot(v, o, s, e);
        // voice_free changes only once the first slot is on the bus, so the
        // previous frame's last slot still sees the old mask.
        if (v == 0 && o == 0) voice_free = free;
        if (!free[v]) acc += (s * e) >>> 8;
      end
    end
    r = reduce(acc);
    ent = {cnt[V_WIDTH:0], r[OUT_WIDTH-1:0]};
    exp_q.push_back(ent);
    exp_cyc_q.push_back(cyc + 3);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst         = 1'b1;
    slot_valid  = 1'b0;
    vx          = '0;
    ox          = '0;
    sine_in     = '0;
    env_level   = '0;
    voice_free  = '0;
    seq_err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mix_out", int'(mix_out), 0);
    check("rst_mix_valid", int'(mix_valid), 0);
    check("rst_seq_err", int'(seq_err), 0);
    check("rst_active_cnt", int'(voice_active_cnt), 0);
    rst = 1'b0;
    idle(2);

    // Full-scale constant frames, with and without free voices.
    send_frame(8'h00, 1'b0, 1024, 255, 0);
    send_frame(8'h03, 1'b0, 1024, 255, 0);
    send_frame(8'h03, 1'b0, 1024, 255, 1);
    idle(1);
    wait_drain();
    check("seq_err_clean", int'(seq_err), 0);

    // Extremes of the sum range.
    send_frame(8'h00, 1'b0, 65535, 255, 0);
    send_frame(8'h00, 1'b0, -65536, 255, 0);
    idle(1);
    wait_drain();

    // Slot skipped inside a frame, followed by a clean frame.
    drive_slot(0, 0, 1000, 200);
    drive_slot(0, 1, 1000, 200);
    drive_slot(0, 3, 1000, 200);
    idle(1);
    check("seq_err_skip", int'(seq_err), 1);
    send_frame(8'h00, 1'b0, 1024, 255, 0);
    idle(1);
    wait_drain();

    // Asynchronous reset in the middle of a frame, away from a clock edge.
    for (int i = 0; i < 10; i++) drive_slot(i / V_OSC, i % V_OSC, 3000, 100);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_mix_out", int'(mix_out), 0);
    check("midrst_mix_valid", int'(mix_valid), 0);
    check("midrst_seq_err", int'(seq_err), 0);
    check("midrst_active_cnt", int'(voice_active_cnt), 0);
    slot_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'h00, 1'b1, 0, 0, 0);
    idle(1);
    wait_drain();

    // Mismatch while clear is held: the set wins. Then a clear on its own.
    seq_err_clr = 1'b1;
    drive_slot(0, 0, 500, 50);
    drive_slot(1, 2, 500, 50);
    idle(1);
    check("seq_err_set_wins", int'(seq_err), 1);
    @(negedge clk);
    check("seq_err_cleared", int'(seq_err), 0);
    seq_err_clr = 1'b0;

    // An out-of-order (0,0) restarts the frame.
    drive_slot(0, 0, 7000, 90);
    drive_slot(0, 1, 7000, 90);
    send_frame(8'h81, 1'b1, 0, 0, 0);
    idle(1);
    check("seq_err_restart", int'(seq_err), 1);
    wait_drain();
    seq_err_clr = 1'b1;
    @(negedge clk);
    seq_err_clr = 1'b0;

    // Random frames: random masks and gaps, some back-to-back.
    for (int f = 0; f < 16; f++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, 0, 0, int'($urandom_range(0, 2)));
    end
    idle(1);
    wait_drain();
    check("seq_err_random", int'(seq_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a wait never ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
